// File: rtl/bcd_pkg.sv
// Shared BCD constants and helpers for the counter controller and its digit cells.
// Pure package: no logic, no latency, no flow control.
package bcd_pkg;

    localparam int             BCD_W          = 4;
    localparam logic [3:0]     BCD_MAX_DIGIT  = 4'd9;
    localparam int             BCD_MAX_DIGITS = 8;

    // Converts a decimal constant to packed BCD, digit 0 in the low nibble.
    function automatic logic [BCD_W*BCD_MAX_DIGITS-1:0] dec_to_bcd(input int unsigned value);
        logic [BCD_W*BCD_MAX_DIGITS-1:0] res;
        int unsigned                     v;
        res = '0;
        v   = value;
        for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
            res[i*BCD_W +: BCD_W] = 4'(v % 10);
            v = v / 10;
        end
        return res;
    endfunction

    function automatic logic [BCD_W-1:0] clamp_nibble(input logic [BCD_W-1:0] n);
        return (n > BCD_MAX_DIGIT) ? BCD_MAX_DIGIT : n;
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit of the up/down step chain; step_in is carry (up) or borrow (down).
// Purely combinational, no backpressure.
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] digit_in,
    input  logic             step_in,
    input  logic             up_dn,
    output logic [BCD_W-1:0] digit_out,
    output logic             step_out
);

    always_comb begin
        digit_out = digit_in;
        step_out  = 1'b0;
        if (step_in) begin
            if (up_dn) begin
                if (digit_in >= BCD_MAX_DIGIT) begin
                    digit_out = '0;
                    step_out  = 1'b1;
                end else begin
                    digit_out = digit_in + 4'd1;
                end
            end else begin
                if (digit_in == '0) begin
                    digit_out = BCD_MAX_DIGIT;
                    step_out  = 1'b1;
                end else begin
                    digit_out = digit_in - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/bcd_counters_controller_gen.sv
// Parametrised up/down BCD counter with prescaler, clamped parallel load, wrap and blink strobes.
// Outputs registered: new count, wrap and blink appear one clock after the tick/load edge; no backpressure.
module bcd_counters_controller_gen
    import bcd_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int MAX_VALUE = 9675,
    parameter int PRESCALE  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic                  up_dn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_data,
    output logic [4*DIGITS-1:0]   Qdata,
    output logic [DIGITS-1:0]     blink,
    output logic                  wrap
);

    localparam int W  = BCD_W * DIGITS;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]                     PRES_LAST = PW'(PRESCALE - 1);
    localparam logic [BCD_W*BCD_MAX_DIGITS-1:0]   MAX_FULL  = dec_to_bcd(MAX_VALUE);
    localparam logic [W-1:0]                      MAX_BCD   = MAX_FULL[W-1:0];

    if (DIGITS < 1 || DIGITS > BCD_MAX_DIGITS) begin : g_bad_digits
        $error("bcd_counters_controller_gen: DIGITS must be 1..8");
    end
    if (MAX_VALUE < 0 || MAX_VALUE >= 10**DIGITS) begin : g_bad_max
        $error("bcd_counters_controller_gen: MAX_VALUE must be < 10**DIGITS");
    end
    if (PRESCALE < 1) begin : g_bad_pres
        $error("bcd_counters_controller_gen: PRESCALE must be >= 1");
    end

    logic [W-1:0]      qdata_q, qdata_d;
    logic [DIGITS-1:0] blink_q, blink_d;
    logic              wrap_q, wrap_d;
    logic [PW-1:0]     pres_cnt_q, pres_cnt_d;

    logic [W-1:0]      step_val;
    logic [DIGITS-1:0] step_chain;
    logic              top_step_unused;
    logic [W-1:0]      load_clamped;
    logic [W-1:0]      load_val;
    logic              tick;
    logic              at_max;
    logic              at_zero;

    // Step chain: digit 0 always steps, higher digits step on carry/borrow.
    assign step_chain[0] = 1'b1;
    for (genvar g = 0; g < DIGITS; g++) begin : g_cell
        if (g < DIGITS - 1) begin : g_mid
            bcd_digit_cell u_cell (
                .digit_in  (qdata_q[g*BCD_W +: BCD_W]),
                .step_in   (step_chain[g]),
                .up_dn     (up_dn),
                .digit_out (step_val[g*BCD_W +: BCD_W]),
                .step_out  (step_chain[g+1])
            );
        end else begin : g_top
            bcd_digit_cell u_cell (
                .digit_in  (qdata_q[g*BCD_W +: BCD_W]),
                .step_in   (step_chain[g]),
                .up_dn     (up_dn),
                .digit_out (step_val[g*BCD_W +: BCD_W]),
                .step_out  (top_step_unused)
            );
        end
    end

    always_comb begin
        load_clamped = '0;
        for (int i = 0; i < DIGITS; i++) begin
            load_clamped[i*BCD_W +: BCD_W] = clamp_nibble(load_data[i*BCD_W +: BCD_W]);
        end
    end

    // With every nibble <= 9, packed BCD orders the same as its decimal value.
    assign load_val = (load_clamped > MAX_BCD) ? MAX_BCD : load_clamped;
    assign tick     = ena && (pres_cnt_q == PRES_LAST);
    assign at_max   = (qdata_q == MAX_BCD);
    assign at_zero  = (qdata_q == '0);

    always_comb begin
        qdata_d    = qdata_q;
        pres_cnt_d = pres_cnt_q;
        wrap_d     = 1'b0;
        if (load) begin
            qdata_d    = load_val;
            pres_cnt_d = '0;
        end else if (ena) begin
            pres_cnt_d = tick ? '0 : pres_cnt_q + 1'b1;
            if (tick) begin
                if (up_dn && at_max) begin
                    qdata_d = '0;
                    wrap_d  = 1'b1;
                end else if (!up_dn && at_zero) begin
                    qdata_d = MAX_BCD;
                    wrap_d  = 1'b1;
                end else begin
                    qdata_d = step_val;
                end
            end
        end
    end

    always_comb begin
        blink_d = '0;
        for (int i = 0; i < DIGITS; i++) begin
            blink_d[i] = (qdata_d[i*BCD_W +: BCD_W] != qdata_q[i*BCD_W +: BCD_W]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            qdata_q    <= '0;
            blink_q    <= '0;
            wrap_q     <= 1'b0;
            pres_cnt_q <= '0;
        end else begin
            qdata_q    <= qdata_d;
            blink_q    <= blink_d;
            wrap_q     <= wrap_d;
            pres_cnt_q <= pres_cnt_d;
        end
    end

    assign Qdata = qdata_q;
    assign blink = blink_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_bcd_counters_controller_gen.sv
// Directed bench for the BCD counter controller: a PRESCALE=1 instance and a PRESCALE=3 instance.
// Expected outputs are queued when each step is driven and compared one clock later.
module tb_bcd_counters_controller_gen;

    typedef struct {
        bit          sel;
        logic [15:0] q;
        logic [3:0]  b;
        logic        w;
        string       tag;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        ena, up_dn, load;
    logic [15:0] load_data;
    logic [15:0] q1;
    logic [3:0]  blink1;
    logic        wrap1;

    logic        ena3, up_dn3, load3;
    logic [15:0] load_data3;
    logic [15:0] q3;
    logic [3:0]  blink3;
    logic        wrap3;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;

    bcd_counters_controller_gen #(.DIGITS(4), .MAX_VALUE(9675), .PRESCALE(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .up_dn     (up_dn),
        .load      (load),
        .load_data (load_data),
        .Qdata     (q1),
        .blink     (blink1),
        .wrap      (wrap1)
    );

    bcd_counters_controller_gen #(.DIGITS(4), .MAX_VALUE(9675), .PRESCALE(3)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena3),
        .up_dn     (up_dn3),
        .load      (load3),
        .load_data (load_data3),
        .Qdata     (q3),
        .blink     (blink3),
        .wrap      (wrap3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic compare_front();
        exp_t x;
        x = sb.pop_front();
        if (x.sel) begin
            chk({x.tag, ".q"},     32'(q3),     32'(x.q));
            chk({x.tag, ".blink"}, 32'(blink3), 32'(x.b));
            chk({x.tag, ".wrap"},  32'(wrap3),  32'(x.w));
        end else begin
            chk({x.tag, ".q"},     32'(q1),     32'(x.q));
            chk({x.tag, ".blink"}, 32'(blink1), 32'(x.b));
            chk({x.tag, ".wrap"},  32'(wrap1),  32'(x.w));
        end
    endtask

    task automatic step(input logic r, input logic e, input logic u, input logic l,
                        input logic [15:0] ld, input logic [15:0] eq, input logic [3:0] eb,
                        input logic ew, input string tag);
        exp_t x;
        rst = r; ena = e; up_dn = u; load = l; load_data = ld;
        x.sel = 1'b0; x.q = eq; x.b = eb; x.w = ew; x.tag = tag;
        sb.push_back(x);
        @(posedge clk);
        #1;
        compare_front();
    endtask

    task automatic step3(input logic e, input logic l, input logic [15:0] ld,
                         input logic [15:0] eq, input logic [3:0] eb, input logic ew,
                         input string tag);
        exp_t x;
        ena3 = e; load3 = l; load_data3 = ld;
        x.sel = 1'b1; x.q = eq; x.b = eb; x.w = ew; x.tag = tag;
        sb.push_back(x);
        @(posedge clk);
        #1;
        compare_front();
    endtask

    initial begin
        rst = 1'b0; ena = 1'b0; up_dn = 1'b1; load = 1'b0; load_data = '0;
        ena3 = 1'b0; up_dn3 = 1'b1; load3 = 1'b0; load_data3 = '0;

        // Reset and mid-count reset
        step(0, 1, 1, 0, 16'h0000, 16'h0000, 4'b0000, 0, "reset_hold");
        step3(0, 0, 16'h0000, 16'h0000, 4'b0000, 0, "reset3");
        step(1, 1, 1, 0, 16'h0000, 16'h0001, 4'b0001, 0, "post_reset");
        step(1, 1, 1, 0, 16'h0000, 16'h0002, 4'b0001, 0, "count2");
        step(0, 1, 1, 0, 16'h0000, 16'h0000, 4'b0000, 0, "mid_reset");
        step(1, 1, 1, 0, 16'h0000, 16'h0001, 4'b0001, 0, "restart");

        // Carry chain upward
        step(1, 0, 1, 1, 16'h0009, 16'h0009, 4'b0001, 0, "load_9");
        step(1, 1, 1, 0, 16'h0000, 16'h0010, 4'b0011, 0, "carry");
        step(1, 1, 1, 0, 16'h0000, 16'h0011, 4'b0001, 0, "after_carry");

        // Up wrap at MAX_VALUE
        step(1, 0, 1, 1, 16'h9674, 16'h9674, 4'b1111, 0, "load_9674");
        step(1, 1, 1, 0, 16'h0000, 16'h9675, 4'b0001, 0, "reach_max");
        step(1, 1, 1, 0, 16'h0000, 16'h0000, 4'b1111, 1, "up_wrap");
        step(1, 1, 1, 0, 16'h0000, 16'h0001, 4'b0001, 0, "post_wrap");

        // Down wrap at zero and borrow chain
        step(1, 0, 1, 1, 16'h0000, 16'h0000, 4'b0001, 0, "load_0");
        step(1, 1, 0, 0, 16'h0000, 16'h9675, 4'b1111, 1, "down_wrap");
        step(1, 1, 0, 0, 16'h0000, 16'h9674, 4'b0001, 0, "down_step");
        step(1, 0, 0, 1, 16'h0100, 16'h0100, 4'b1111, 0, "load_100");
        step(1, 1, 0, 0, 16'h0000, 16'h0099, 4'b0111, 0, "borrow");

        // Load clamping and load/tick priority
        step(1, 0, 1, 1, 16'h9A99, 16'h9675, 4'b1111, 0, "clamp_max");
        step(1, 0, 1, 1, 16'h12F3, 16'h1293, 4'b1111, 0, "clamp_nib");
        step(1, 1, 1, 1, 16'h0500, 16'h0500, 4'b1111, 0, "load_on_tick");
        step(1, 1, 1, 1, 16'h0500, 16'h0500, 4'b0000, 0, "load_same");
        step(1, 0, 1, 1, 16'h9675, 16'h9675, 4'b1111, 0, "load_max");
        step(1, 1, 1, 1, 16'h9675, 16'h9675, 4'b0000, 0, "load_beats_wrap");
        step(1, 0, 0, 0, 16'h0000, 16'h9675, 4'b0000, 0, "hold_disabled");

        // Prescaler and enable on the PRESCALE=3 instance
        step3(1, 0, 16'h0000, 16'h0000, 4'b0000, 0, "pre1");
        step3(1, 0, 16'h0000, 16'h0000, 4'b0000, 0, "pre2");
        step3(1, 0, 16'h0000, 16'h0001, 4'b0001, 0, "tick1");
        for (int i = 0; i < 5; i++)
            step3(0, 0, 16'h0000, 16'h0001, 4'b0000, 0, "ena_low_hold");
        step3(1, 0, 16'h0000, 16'h0001, 4'b0000, 0, "pre3");
        step3(1, 0, 16'h0000, 16'h0001, 4'b0000, 0, "pre4");
        step3(1, 0, 16'h0000, 16'h0002, 4'b0001, 0, "tick2");
        step3(1, 0, 16'h0000, 16'h0002, 4'b0000, 0, "partial");
        step3(0, 1, 16'h0042, 16'h0042, 4'b0010, 0, "load_disabled");
        step3(1, 0, 16'h0000, 16'h0042, 4'b0000, 0, "pres_cleared1");
        step3(1, 0, 16'h0000, 16'h0042, 4'b0000, 0, "pres_cleared2");
        step3(1, 0, 16'h0000, 16'h0043, 4'b0001, 0, "tick3");

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bcd_counters_controller_gen.md
Name: bcd_counters_controller_gen

Overview:
Parametrised multi-digit BCD counter controller, the successor to the fixed 4-digit 0..9675 counter.
- Generalised in digit count, terminal value and tick rate.
- Adds up/down mode, parallel load, a wrap pulse and per-digit change strobes (blink).
- Feeds the display/blink logic of the top level; Qdata packs DIGITS BCD nibbles, digit 0 in bits [3:0].

Parameters:
DIGITS, 4, number of BCD digits (1..8)
MAX_VALUE, 9675, terminal decimal value; must be < 10^DIGITS (elaboration error otherwise)
PRESCALE, 1, clocks per count tick while ena=1 (>=1)

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  reset, synchronous, active-low
ena  in  1  count enable; gates the prescaler
up_dn  in  1  1 = count up, 0 = count down; sampled at each tick
load  in  1  parallel load request, single-cycle
load_data  in  4*DIGITS  BCD value to load
Qdata  out  4*DIGITS  current count, packed BCD
blink  out  DIGITS  blink[i]=1 for one clock after digit i changed value
wrap  out  1  one-clock pulse when the count wraps at a terminal value

Behaviour:
- One clock domain; every output is registered.
- rst=0 at an edge: Qdata=0, blink=0, wrap=0, prescaler=0. Effective on that edge, mid-count included.
- Priority at each edge: rst > load > tick.
- Prescaler: pres_cnt counts 0..PRESCALE-1 only while ena=1. It holds while ena=0.
- Tick: occurs on the edge where pres_cnt wraps to 0. With PRESCALE=1 every enabled edge is a tick.
- Tick, up_dn=1:
  - Qdata==MAX_VALUE -> 0, wrap=1.
  - Otherwise BCD increment: digit 9 -> 0 with carry to the next digit.
- Tick, up_dn=0:
  - Qdata==0 -> MAX_VALUE, wrap=1.
  - Otherwise BCD decrement: digit 0 -> 9 with borrow from the next digit.
- Latency: the new Qdata appears in the cycle after the tick edge. wrap and blink are valid in the same cycle as the new Qdata, for exactly one clock.
- blink[i]=1 iff digit i changed on the previous edge. This covers ticks and loads; a load of the same value gives blink=0.
- Load:
  - Ignores ena.
  - Any nibble >9 is clamped to 9.
  - If the resulting value > MAX_VALUE, MAX_VALUE is loaded.
  - Resets the prescaler to 0.
  - wrap=0 on a load.
- Load coincident with a tick: load wins and the tick is discarded (not deferred).
- up_dn change: takes effect at the next tick. No glitch on Qdata.
- Invariants: Qdata <= MAX_VALUE and every nibble <= 9 at all times after reset.
- No state machine beyond the prescaler and count registers; the terminal compare is combinational on registered Qdata.

Decomposition:
- Shared package/include bcd_pkg:
  - BCD_W=4
  - BCD_MAX_DIGIT=4'd9
  - a function converting a decimal parameter to packed BCD (used for MAX_VALUE)
  - a nibble-clamp function
- One sub-module, bcd_digit_cell:
  - inputs: digit value, step_in (carry/borrow), up_dn
  - outputs: next digit, step_out
  - instanced DIGITS times via generate.
- The top level holds the prescaler, terminal compare, load path and output registers.

Test Plan:
1. Reset: ena=1, counting; drive rst=0 for one edge -> next cycle Qdata=16'h0000, blink=0, wrap=0. rst=1 with PRESCALE=1 -> 16'h0001 one edge later.
2. Carry chain, up: load 16'h0009, ena=1 -> Qdata=16'h0010, blink=4'b0011 for one cycle; next edge 16'h0011, blink=4'b0001.
3. Up wrap: load 16'h9674, two ticks -> 16'h9675, then 16'h0000 with wrap=1 and blink=4'b1111 for one cycle; next tick 16'h0001, wrap=0.
4. Down wrap: load 16'h0000, up_dn=0, one tick -> 16'h9675, wrap=1, blink=4'b1111; next tick 16'h9674. Loading 16'h0100 then one tick -> 16'h0099.
5. Load clamp: load_data=16'h9A99 -> Qdata=16'h9675. load_data=16'h12F3 -> Qdata=16'h1293. Load asserted on a tick edge -> loaded value shown, no increment.
6. Prescale/enable: PRESCALE=3, start 0. ena high for 3 clocks -> 16'h0001. ena low 5 clocks -> Qdata holds. ena high 3 more -> 16'h0002. ena=0 with load=1 -> load still applied.
